// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit engine.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP1  = 3'b100,
        STOP2  = 3'b101
    } tx_state_e;

    localparam int unsigned MIN_DATA_W = 5;

    // Parity over bits [wls:0]; sp forces the bit to ~eps, eps selects even parity.
    function automatic logic calc_parity(input logic [31:0] data, input int unsigned wls,
                                         input logic eps, input logic sp);
        logic ones;
        ones = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i <= wls) ones ^= data[i];
        end
        if (sp) return ~eps;
        return eps ? ones : ~ones;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Valid/ready payload channel between the TX FIFO and the transmit engine.
interface uart_tx_engine_if #(
    parameter int unsigned DATA_W = 8
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_shifter.sv
// Data shift register, bit counter and frame parity bit for the UART transmitter.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WLS_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic              count,
    input  logic [DATA_W-1:0] data,
    input  logic [WLS_W-1:0]  wls,
    input  logic              eps,
    input  logic              sp,
    output logic              bit_out,
    output logic              last,
    output logic              par_bit
);

    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] masked;
    logic [WLS_W-1:0]  cnt_q;
    logic [WLS_W-1:0]  wls_q;
    logic              par_q;

    // Keep only bits [wls:0] so unused upper payload bits never reach the line.
    assign masked = data & ({DATA_W{1'b1}} >> (WLS_W'(DATA_W - 1) - wls));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            wls_q   <= '0;
            par_q   <= 1'b0;
        end else if (load) begin
            shreg_q <= masked;
            cnt_q   <= '0;
            wls_q   <= wls;
            par_q   <= calc_parity(32'(masked), 32'(wls), eps, sp);
        end else begin
            if (shift) shreg_q <= shreg_q >> 1;
            if (count) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bit_out = shreg_q[0];
    assign last    = (cnt_q == wls_q);
    assign par_bit = par_q;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: frame FSM driving the pad, paced by tx_tick.
// Optional line break (brk port) when UART_TX_BREAK_EN is defined.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WLS_W  = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               tx_tick,
    uart_tx_engine_if.slave    fifo,
    input  logic [WLS_W-1:0]   wls,
    input  logic               pen,
    input  logic               eps,
    input  logic               sp,
    input  logic               stb,
`ifdef UART_TX_BREAK_EN
    input  logic               brk,
`endif
    output logic               tx,
    output logic               tx_busy,
    output logic               tx_done
);

    localparam logic [WLS_W-1:0] WlsMin = WLS_W'(MIN_DATA_W - 1);
    localparam logic [WLS_W-1:0] WlsMax = WLS_W'(DATA_W - 1);

    tx_state_e        state_q, state_d;
    logic             fsm_tx_q, fsm_tx_d;
    logic             pen_q, stb_q;
    logic             done_q, done_d;
    logic             load, shift, count, frame_end;
    logic             sh_bit, sh_last, par_bit;
    logic             last_stop, hs;
    logic [WLS_W-1:0] wls_hi, wls_eff;

    // Upper clamp only exists when the wls field can encode more than DATA_W bits.
    if ((1 << WLS_W) > DATA_W) begin : g_clamp_hi
        assign wls_hi = (wls > WlsMax) ? WlsMax : wls;
    end else begin : g_no_clamp_hi
        assign wls_hi = wls;
    end
    assign wls_eff = (wls_hi < WlsMin) ? WlsMin : wls_hi;

    assign last_stop     = (state_q == STOP2) || ((state_q == STOP1) && !stb_q);
    assign fifo.tx_ready = rst_n & en & tx_tick & ((state_q == IDLE) | last_stop);
    assign hs            = fifo.tx_valid & fifo.tx_ready;

    uart_tx_shifter #(
        .DATA_W (DATA_W),
        .WLS_W  (WLS_W)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .shift   (shift),
        .count   (count),
        .data    (fifo.tx_data),
        .wls     (wls_eff),
        .eps     (eps),
        .sp      (sp),
        .bit_out (sh_bit),
        .last    (sh_last),
        .par_bit (par_bit)
    );

    always_comb begin
        state_d   = state_q;
        fsm_tx_d  = fsm_tx_q;
        load      = 1'b0;
        shift     = 1'b0;
        count     = 1'b0;
        done_d    = 1'b0;
        frame_end = 1'b0;
        if (tx_tick) begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        state_d  = START;
                        fsm_tx_d = 1'b0;
                        load     = 1'b1;
                    end
                end
                START: begin
                    state_d  = DATA;
                    fsm_tx_d = sh_bit;
                    shift    = 1'b1;
                end
                DATA: begin
                    if (sh_last) begin
                        state_d  = pen_q ? PARITY : STOP1;
                        fsm_tx_d = pen_q ? par_bit : 1'b1;
                    end else begin
                        fsm_tx_d = sh_bit;
                        shift    = 1'b1;
                        count    = 1'b1;
                    end
                end
                PARITY: begin
                    state_d  = STOP1;
                    fsm_tx_d = 1'b1;
                end
                STOP1: begin
                    if (stb_q) begin
                        state_d  = STOP2;
                        fsm_tx_d = 1'b1;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
                STOP2:   frame_end = 1'b1;
                default: begin
                    state_d  = IDLE;
                    fsm_tx_d = 1'b1;
                end
            endcase
            // A handshake on the closing tick chains straight into the next start bit.
            if (frame_end) begin
                done_d = 1'b1;
                if (hs) begin
                    state_d  = START;
                    fsm_tx_d = 1'b0;
                    load     = 1'b1;
                end else begin
                    state_d  = IDLE;
                    fsm_tx_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            fsm_tx_q <= 1'b1;
            pen_q    <= 1'b0;
            stb_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fsm_tx_q <= fsm_tx_d;
            done_q   <= done_d;
            if (load) begin
                pen_q <= pen;
                stb_q <= stb;
            end
        end
    end

`ifdef UART_TX_BREAK_EN
    logic line_q;

    // Break overrides the pad every clock while the FSM keeps advancing underneath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) line_q <= 1'b1;
        else        line_q <= fsm_tx_d & ~brk;
    end
    assign tx = line_q;
`else
    assign tx = fsm_tx_q;
`endif

    assign tx_busy = (state_q != IDLE);
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: expected line bits queued by stimulus, checked per tick.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       tx_tick = 1'b0;
    logic [2:0] wls = 3'd7;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sp = 1'b0;
    logic       stb = 1'b0;
    logic       brk = 1'b0;
    logic       tx, tx_busy, tx_done;

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   tick_div = 0;
    logic exp_q[$];

    uart_tx_engine_if #(.DATA_W(8)) ifc ();

    uart_tx_engine #(.DATA_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .tx_tick (tx_tick),
        .fifo    (ifc),
        .wls     (wls),
        .pen     (pen),
        .eps     (eps),
        .sp      (sp),
        .stb     (stb),
`ifdef UART_TX_BREAK_EN
        .brk     (brk),
`endif
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #10 clk = ~clk;

    // Divisor 5: one-clock tick every fifth clock.
    always @(posedge clk) begin
        if (tick_div == 4) begin
            tick_div <= 0;
            tx_tick  <= 1'b1;
        end else begin
            tick_div <= tick_div + 1;
            tx_tick  <= 1'b0;
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    // Monitor: one line sample per tick, shortly after the tick edge.
    initial begin
        logic brk_edge;
        logic b;
        forever begin
            @(negedge clk);
            if (tx_tick) begin
                brk_edge = brk;
                @(posedge clk);
                #1;
                if (tx_busy) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty: got=busy_bit want=no_frame");
                    end else begin
                        b = exp_q.pop_front();
                        check("tx_bit", int'(tx), brk_edge ? 0 : int'(b));
                    end
                end else begin
                    check("tx_idle", int'(tx), 1);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_done) done_cnt++;
        end
    end

    task automatic push(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
    endtask

    task automatic wait_hs(output int nticks, output int ok);
        nticks = 0;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_tick) nticks++;
            if (ifc.tx_valid && ifc.tx_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                return;
            end
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                if (tx_tick) break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(output int ticks);
        ticks = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_tick) begin
                @(posedge clk);
                #1;
                if (tx_busy) ticks++;
                else return;
            end
        end
        ticks = -1;
    endtask

    task automatic send(input string name, input logic [7:0] d, input logic [2:0] w,
                        input logic p, input logic e, input logic s, input logic st,
                        input int exp_ticks);
        int n, ok, t, d0;
        wls = w; pen = p; eps = e; sp = s; stb = st;
        ifc.tx_data  = d;
        ifc.tx_valid = 1'b1;
        wait_hs(n, ok);
        ifc.tx_valid = 1'b0;
        check({name, "_hs"}, ok, 1);
        d0 = done_cnt;
        // Scramble config mid-frame; the frame in flight must not notice.
        wls = ~w; pen = ~p; eps = ~e; sp = ~s; stb = ~st;
        ifc.tx_data = ~d;
        wait_idle(t);
        #2;
        check({name, "_len"}, t, exp_ticks);
        check({name, "_done"}, done_cnt - d0, 1);
    endtask

    initial begin
        int n, ok, t, d0, rdy;
        ifc.tx_valid = 1'b1;
        ifc.tx_data  = 8'h00;
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_tick) break;
        end
        check("rst_ready", int'(ifc.tx_ready), 0);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_done", int'(tx_done), 0);
        ifc.tx_valid = 1'b0;
        @(posedge clk);
        #5 rst_n = 1'b1;
        wait_ticks(3);

        // 8N1 0xA5
        push(16'b0101001011, 10);
        send("f8n1", 8'hA5, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        // 7E2 0x35
        push(16'b01010110011, 11);
        send("f7e2", 8'h35, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 11);
        // 5O1 0xFF, upper bits masked
        push(16'b01111101, 8);
        send("f5o1", 8'hFF, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        // Stick parity: sp=1 eps=0 -> parity 1; sp=1 eps=1 -> parity 0
        push(16'b00000000011, 11);
        send("stick1", 8'h00, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 11);
        push(16'b01000000001, 11);
        send("stick0", 8'h01, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 11);
        // Illegal wls=2 behaves as 5 data bits; 0xF3 -> 1,1,0,0,1
        push(16'b0110011, 7);
        send("wls_min", 8'hF3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7);

        // Back-to-back 8N1: 0xA5 then 0x3C with no idle bit
        push(16'b0101001011, 10);
        push(16'b0001111001, 10);
        wls = 3'd7; pen = 1'b0; eps = 1'b0; sp = 1'b0; stb = 1'b0;
        d0 = done_cnt;
        ifc.tx_data  = 8'hA5;
        ifc.tx_valid = 1'b1;
        wait_hs(n, ok);
        check("b2b_hs1", ok, 1);
        ifc.tx_data = 8'h3C;
        wait_hs(n, ok);
        ifc.tx_valid = 1'b0;
        check("b2b_hs2", ok, 1);
        check("b2b_gap", n, 10);
        check("b2b_busy", int'(tx_busy), 1);
        check("b2b_tx_start", int'(tx), 0);
        wait_idle(t);
        #2;
        check("b2b_len", t, 10);
        check("b2b_done", done_cnt - d0, 2);

        // Reset in the middle of DATA
        push(16'b0101001011, 10);
        ifc.tx_data  = 8'hA5;
        ifc.tx_valid = 1'b1;
        wait_hs(n, ok);
        ifc.tx_valid = 1'b0;
        check("rmid_hs", ok, 1);
        wait_ticks(3);
        d0 = done_cnt;
        #4 rst_n = 1'b0;
        #1;
        check("rmid_tx", int'(tx), 1);
        check("rmid_busy", int'(tx_busy), 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #5 rst_n = 1'b1;
        wait_ticks(3);
        #2;
        check("rmid_nodone", done_cnt - d0, 0);
        push(16'b0010110101, 10);
        send("rmid_next", 8'h5A, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 10);

        // en dropped mid-frame: frame completes, nothing else accepted
        push(16'b0101001011, 10);
        wls = 3'd7; pen = 1'b0; eps = 1'b0; sp = 1'b0; stb = 1'b0;
        ifc.tx_data  = 8'hA5;
        ifc.tx_valid = 1'b1;
        wait_hs(n, ok);
        check("en_hs", ok, 1);
        en = 1'b0;
        d0 = done_cnt;
        rdy = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (ifc.tx_ready) rdy++;
        end
        check("en_done", done_cnt - d0, 1);
        check("en_noready", rdy, 0);
        check("en_idle", int'(tx_busy), 0);
        ifc.tx_valid = 1'b0;
        en = 1'b1;

`ifdef UART_TX_BREAK_EN
        // Break during DATA forces the line low; FSM carries on underneath
        push(16'b0101001011, 10);
        ifc.tx_data  = 8'hA5;
        ifc.tx_valid = 1'b1;
        wait_hs(n, ok);
        ifc.tx_valid = 1'b0;
        check("brk_hs", ok, 1);
        d0 = done_cnt;
        wait_ticks(2);
        brk = 1'b1;
        @(posedge clk);
        #1;
        check("brk_low", int'(tx), 0);
        wait_ticks(3);
        brk = 1'b0;
        wait_idle(t);
        #2;
        check("brk_done", done_cnt - d0, 1);
`endif

        wait_ticks(2);
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
